// File: rtl/uart_pkg.sv
// Shared types for the configurable UART transmitter: parity selection,
// FSM state names and a parity helper.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    // Parity of a zero-extended payload; unused upper bits must be zero.
    function automatic logic parity_bit(input logic [8:0] data, input parity_t mode);
        logic p;
        p = ^data;
        return (mode == PAR_ODD) ? ~p : p;
    endfunction

endpackage

// File: rtl/uart_transmit_cfg_if.sv
// Word handshake between a producer and the UART transmitter.
interface uart_transmit_cfg_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_in;
    logic                 valid_in;
    logic                 ready_out;

    modport master (output data_in, output valid_in, input ready_out);
    modport slave  (input data_in, input valid_in, output ready_out);
endinterface

// File: rtl/uart_tx_fifo.sv
// Show-ahead synchronous FIFO holding words waiting for transmission.
module uart_tx_fifo #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             push_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic             pop_in,
    output logic [WIDTH-1:0] head_out,
    output logic [CW-1:0]    count_out
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [CW-1:0]    count_q;
    logic             do_push_c;
    logic             do_pop_c;

    // A push while full is accepted only when a pop frees the slot on the same edge.
    assign do_pop_c  = pop_in && (count_q != '0);
    assign do_push_c = push_in && ((count_q != CW'(DEPTH)) || do_pop_c);
    assign head_out  = mem_q[rd_q];
    assign count_out = count_q;

    // Storage array, written at the write pointer.
    always_ff @(posedge clk_in) begin
        if (do_push_c) begin
            mem_q[wr_q] <= data_in;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push_c) wr_q <= wr_q + AW'(1);
            if (do_pop_c)  rd_q <= rd_q + AW'(1);
            case ({do_push_c, do_pop_c})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_transmit_cfg.sv
// Configurable UART transmitter: start bit, LSB-first data, optional parity,
// one or two stop bits. Define UART_TX_FIFO_EN to buffer FIFO_DEPTH words;
// otherwise a single holding register is used.
module uart_transmit_cfg
    import uart_pkg::*;
#(
    parameter  int unsigned INPUT_CLOCK_FREQ = 100_000_000,
    parameter  int unsigned BAUD_RATE        = 460800,
    parameter  int unsigned DATA_BITS        = 8,
    parameter  parity_t     PARITY           = PAR_NONE,
    parameter  int unsigned STOP_BITS        = 1,
    parameter  int unsigned FIFO_DEPTH       = 16,
    localparam int unsigned CNT_W            = $clog2(FIFO_DEPTH + 1)
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    uart_transmit_cfg_if.slave bus,
    output logic [CNT_W-1:0]   count_out,
    output logic               busy_out,
    output logic               tx_wire_out
);
    localparam int unsigned BIT_PERIOD = INPUT_CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned CW         = $clog2(BIT_PERIOD);
    localparam int unsigned BW         = $clog2(DATA_BITS);
    localparam int unsigned CNT_X      = CNT_W + 1;
    localparam bit          HAS_PAR    = (PARITY != PAR_NONE);

    localparam logic [2:0] S_IDLE   = TX_IDLE;
    localparam logic [2:0] S_START  = TX_START;
    localparam logic [2:0] S_DATA   = TX_DATA;
    localparam logic [2:0] S_PARITY = TX_PARITY;
    localparam logic [2:0] S_STOP   = TX_STOP;

    logic                 push_c;
    logic                 pop_c;
    logic [DATA_BITS-1:0] head_c;
    logic [CNT_W-1:0]     count_c;
    logic [CNT_X-1:0]     count_nxt_c;
    logic                 ready_q;

    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        idx_q, idx_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 bit_end_c;
    logic                 load_c;

    assign push_c = bus.valid_in && ready_q;

`ifdef UART_TX_FIFO_EN
    localparam int unsigned CAP = FIFO_DEPTH;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .push_in   (push_c),
        .data_in   (bus.data_in),
        .pop_in    (pop_c),
        .head_out  (head_c),
        .count_out (count_c)
    );
`else
    localparam int unsigned CAP = 1;

    logic [DATA_BITS-1:0] hold_q;
    logic                 hold_v_q;

    // Single-word holding register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hold_q   <= '0;
            hold_v_q <= 1'b0;
        end else begin
            if (push_c) hold_q <= bus.data_in;
            hold_v_q <= push_c | (hold_v_q & ~pop_c);
        end
    end

    assign head_c  = hold_q;
    assign count_c = CNT_W'(hold_v_q);
`endif

    assign count_nxt_c   = {1'b0, count_c} + CNT_X'(push_c) - CNT_X'(pop_c);
    assign bus.ready_out = ready_q;
    assign count_out     = count_c;
    assign busy_out      = (state_q != S_IDLE) || (count_c != '0);
    assign tx_wire_out   = tx_q;
    assign bit_end_c     = (cnt_q == CW'(BIT_PERIOD - 1));

    // Ready tracks the post-edge occupancy so it stays low through reset.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= (count_nxt_c < CNT_X'(CAP));
        end
    end

    // Frame sequencing: next state, bit timing, shift register and line value.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        load_c  = 1'b0;
        pop_c   = 1'b0;

        if (state_q != S_IDLE) begin
            cnt_d = bit_end_c ? '0 : cnt_q + CW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (count_c != '0) load_c = 1'b1;
            end
            S_START: begin
                if (bit_end_c) begin
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    idx_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_end_c) begin
                    if (idx_q == BW'(DATA_BITS - 1)) begin
                        if (HAS_PAR) begin
                            state_d = S_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                            stop_d  = 1'b0;
                        end
                    end else begin
                        idx_d   = idx_q + BW'(1);
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end_c) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                    stop_d  = 1'b0;
                end
            end
            S_STOP: begin
                if (bit_end_c) begin
                    if (stop_q == 1'(STOP_BITS - 1)) begin
                        if (count_c != '0) begin
                            load_c = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Pop the head word and drive the start bit on the same edge.
        if (load_c) begin
            state_d = S_START;
            tx_d    = 1'b0;
            pop_c   = 1'b1;
            cnt_d   = '0;
            shift_d = head_c;
            par_d   = parity_bit(9'(head_c), PARITY);
        end
    end

    // FSM and datapath registers; reset forces the line idle high.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

endmodule
